// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
//   Start/done handshake and operand/result bus of the bit-serial subtractor.
//   master : requester side (drives start/a/b, observes status and result)
//   slave  : subtractor side
//   start       request, sampled only while the subtractor is idle
//   a, b        minuend / subtrahend, captured on an accepted start
//   busy        high while an operation is in flight
//   done        one-cycle pulse, result fields valid
//   diff        (a - b) mod 2^WIDTH
//   borrow_out  borrow out of the MSB stage (a < b unsigned)
//   zero        diff == 0
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic             zero;

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow_out, zero
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow_out, zero
   );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor, LSB first, one bit per clock through a
//   full-subtractor cell with a registered borrow. Result fields are held
//   from one done pulse to the next.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  serial_subtractor_if slave: start/a/b in, busy/done/diff/borrow_out/zero out
//
// state | meaning
// IDLE  | waiting for start, operands captured on accept
// SHIFT | one difference bit per cycle, WIDTH cycles
// DONE  | done pulse, result registers just updated
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   serial_subtractor_if.slave bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             br;
   logic [CW-1:0]    cnt;

   logic             x;
   logic             y;
   logic             d;
   logic             br_next;
   logic [WIDTH-1:0] res_next;

   always_comb begin
      x        = a_sh[0];
      y        = b_sh[0];
      d        = x ^ y ^ br;
      br_next  = (~x & y) | (~(x ^ y) & br);
      // New bit enters at the MSB; after WIDTH shifts the first (LSB) bit sits at bit 0.
      res_next = {d, res_sh[WIDTH-1:1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         a_sh           <= '0;
         b_sh           <= '0;
         res_sh         <= '0;
         br             <= 1'b0;
         cnt            <= '0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.diff       <= '0;
         bus.borrow_out <= 1'b0;
         bus.zero       <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  a_sh     <= bus.a;
                  b_sh     <= bus.b;
                  res_sh   <= '0;
                  br       <= 1'b0;
                  cnt      <= '0;
                  bus.busy <= 1'b1;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               res_sh <= res_next;
               br     <= br_next;
               if (cnt == CNT_LAST) begin
                  bus.diff       <= res_next;
                  bus.borrow_out <= br_next;
                  bus.zero       <= (res_next == '0);
                  bus.done       <= 1'b1;
                  state          <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Directed vectors for the WIDTH=8 subtractor and an exhaustive WIDTH=4 sweep.
`timescale 1ns/1ps
module tb_serial_subtractor;
   logic clk;
   logic rst;

   serial_subtractor_if #(.WIDTH(8)) bus8 ();
   serial_subtractor_if #(.WIDTH(4)) bus4 ();

   serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
   serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

   int n_vec = 0;
   int n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: present start for one edge, then scramble operands.
   task automatic launch8(input logic [7:0] a, input logic [7:0] b);
      bus8.start = 1'b1;
      bus8.a     = a;
      bus8.b     = b;
      @(negedge clk);
      bus8.start = 1'b0;
      bus8.a     = 8'($urandom);
      bus8.b     = 8'($urandom);
   endtask

   // Counts rising edges until done is seen at a negedge (bounded).
   task automatic wait_done8(output int k, output logic seen);
      k    = 0;
      seen = 1'b0;
      while (k < 20 && !seen) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         if (bus8.done) seen = 1'b1;
      end
   endtask

   task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ediff, input logic eborrow, input logic ezero);
      int k;
      logic seen;
      launch8(a, b);
      wait_done8(k, seen);
      chk({tag, "_seen"}, 32'(seen), 32'd1);
      chk({tag, "_lat"}, 32'(k), 32'd8);
      chk({tag, "_diff"}, 32'(bus8.diff), 32'(ediff));
      chk({tag, "_borrow"}, 32'(bus8.borrow_out), 32'(eborrow));
      chk({tag, "_zero"}, 32'(bus8.zero), 32'(ezero));
      chk({tag, "_busy_in_done"}, 32'(bus8.busy), 32'd1);
      @(negedge clk);
      chk({tag, "_busy_after"}, 32'(bus8.busy), 32'd0);
      chk({tag, "_done_after"}, 32'(bus8.done), 32'd0);
   endtask

   initial begin
      int   k;
      logic seen;
      int   extra;

      rst        = 1'b1;
      bus8.start = 1'b0;
      bus8.a     = '0;
      bus8.b     = '0;
      bus4.start = 1'b0;
      bus4.a     = '0;
      bus4.b     = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(bus8.busy), 32'd0);
      chk("rst_done", 32'(bus8.done), 32'd0);
      chk("rst_diff", 32'(bus8.diff), 32'd0);
      chk("rst_borrow", 32'(bus8.borrow_out), 32'd0);
      chk("rst_zero", 32'(bus8.zero), 32'd1);
      rst = 1'b0;
      @(negedge clk);

      op8("basic", 8'd200, 8'd55, 8'd145, 1'b0, 1'b0);
      op8("borrow", 8'd5, 8'd10, 8'hFB, 1'b1, 1'b0);
      op8("equal", 8'h3C, 8'h3C, 8'h00, 1'b0, 1'b1);
      op8("extreme", 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
      op8("max_min", 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);

      // start pulsed during SHIFT must be ignored
      launch8(8'd9, 8'd4);
      bus8.start = 1'b1;
      bus8.a     = 8'd1;
      bus8.b     = 8'd2;
      @(negedge clk);
      bus8.start = 1'b0;
      wait_done8(k, seen);
      chk("ign_seen", 32'(seen), 32'd1);
      chk("ign_lat", 32'(k), 32'd7);
      chk("ign_diff", 32'(bus8.diff), 32'd5);
      chk("ign_borrow", 32'(bus8.borrow_out), 32'd0);
      @(negedge clk);
      chk("ign_busy_after", 32'(bus8.busy), 32'd0);
      extra = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus8.done || bus8.busy) extra++;
      end
      chk("ign_no_second", 32'(extra), 32'd0);

      // asynchronous reset mid-operation
      launch8(8'd100, 8'd1);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(bus8.busy), 32'd0);
      chk("mid_rst_done", 32'(bus8.done), 32'd0);
      chk("mid_rst_diff", 32'(bus8.diff), 32'd0);
      chk("mid_rst_zero", 32'(bus8.zero), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      extra = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus8.done) extra++;
      end
      chk("mid_rst_no_done", 32'(extra), 32'd0);
      op8("after_rst", 8'd7, 8'd3, 8'd4, 1'b0, 1'b0);

      // back-to-back: second start on the cycle busy falls
      launch8(8'd20, 8'd7);
      wait_done8(k, seen);
      chk("b2b1_seen", 32'(seen), 32'd1);
      chk("b2b1_diff", 32'(bus8.diff), 32'd13);
      @(negedge clk);
      chk("b2b1_busy_low", 32'(bus8.busy), 32'd0);
      launch8(8'd3, 8'd9);
      repeat (4) @(negedge clk);
      chk("b2b_hold_diff", 32'(bus8.diff), 32'd13);
      chk("b2b_hold_borrow", 32'(bus8.borrow_out), 32'd0);
      chk("b2b_busy_mid", 32'(bus8.busy), 32'd1);
      wait_done8(k, seen);
      chk("b2b2_seen", 32'(seen), 32'd1);
      chk("b2b2_lat", 32'(k + 4), 32'd8);
      chk("b2b2_diff", 32'(bus8.diff), 32'hFA);
      chk("b2b2_borrow", 32'(bus8.borrow_out), 32'd1);
      chk("b2b2_zero", 32'(bus8.zero), 32'd0);
      @(negedge clk);

      // exhaustive WIDTH=4 sweep
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            int   kk;
            logic s4;
            logic [3:0] ed;
            ed = 4'(ia - ib);
            bus4.start = 1'b1;
            bus4.a     = 4'(ia);
            bus4.b     = 4'(ib);
            @(negedge clk);
            bus4.start = 1'b0;
            bus4.a     = 4'($urandom);
            bus4.b     = 4'($urandom);
            kk = 0;
            s4 = 1'b0;
            while (kk < 12 && !s4) begin
               @(posedge clk);
               kk++;
               @(negedge clk);
               if (bus4.done) s4 = 1'b1;
            end
            chk("w4_done", 32'(s4), 32'd1);
            chk("w4_diff", 32'(bus4.diff), 32'(ed));
            chk("w4_borrow", 32'(bus4.borrow_out), 32'(ia < ib));
            chk("w4_zero", 32'(bus4.zero), 32'(ed == 4'd0));
            @(negedge clk);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
